mc_control: RTL and testbench

Multicycle main controller for the MIPS datapath. A Moore FSM sequences instruction fetch, decode, execute, memory access and writeback over 3–5+ cycles per instruction. It drives every datapath mux select and write enable, and supplies the 2-bit ALU operation class to the ALU control decoder. It sits beside that decoder and stalls on a single-bit memory-ready handshake from the shared instruction/data memory.

---
 rtl/mc_control.sv | 233 +++++++++++++++++++++++
 tb/tb_mc_control.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control.sv
// mc_control -- multicycle main controller for the MIPS datapath.
//
// A Moore FSM that walks each instruction through fetch, decode, execute,
// memory access and writeback. It drives every datapath mux select and
// write enable, and gives the 2-bit ALU operation class to the ALU control
// decoder. It stalls on the single-bit ready handshake from the shared
// instruction/data memory.
//
// Ports
//   i_clk        clock, all state changes on the rising edge
//   i_rst_n      asynchronous active-low reset
//   i_opcode     instruction register [31:26], valid from DECODE onward
//   i_zero       ALU zero flag
//   i_memReady   memory completes the current access this cycle
//   o_aluOp      00 add, 01 sub, 10 decode funct
//   o_aluSrcA    0 PC, 1 register A
//   o_aluSrcB    00 reg B, 01 const 4, 10 sext imm, 11 sext imm<<2
//   o_pcSrc      00 ALU result, 01 ALUOut, 10 jump target
//   o_pcEn       PC load enable
//   o_irWrite    instruction register load
//   o_iorD       memory address: 0 PC, 1 ALUOut
//   o_memWrite   memory write strobe
//   o_regWrite   register file write
//   o_regDst     0 rt, 1 rd
//   o_memtoReg   0 ALUOut, 1 memory data register
//   o_illegal    one-cycle pulse in DECODE on an unsupported opcode
//   o_state      current state encoding, for debug
//
// state  | meaning
// -------+----------------------------------------------------------
// FETCH  | read instruction at PC, PC <= PC+4 when memory is ready
// DECODE | read registers, precompute branch target, dispatch
// MEMADR | compute load/store address
// MEMRD  | load data read, wait for memory
// MEMWB  | write load data to rt
// MEMWR  | store data write, strobe held until memory is ready
// EXEC   | R-type ALU operation
// ALUWB  | write R-type result to rd
// BRANCH | compare registers, take branch on zero
// ADDIEX | addi ALU operation
// ADDIWB | write addi result to rt
// JUMP   | load jump target into PC

module mc_control (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [5:0] i_opcode,
    input  logic       i_zero,
    input  logic       i_memReady,
    output logic [1:0] o_aluOp,
    output logic       o_aluSrcA,
    output logic [1:0] o_aluSrcB,
    output logic [1:0] o_pcSrc,
    output logic       o_pcEn,
    output logic       o_irWrite,
    output logic       o_iorD,
    output logic       o_memWrite,
    output logic       o_regWrite,
    output logic       o_regDst,
    output logic       o_memtoReg,
    output logic       o_illegal,
    output logic [3:0] o_state
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    state_t state;
    state_t state_next;

    logic illegal_dec;
    logic pc_en_raw;
    logic ir_write_raw;
    logic mem_write_raw;
    logic reg_write_raw;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        illegal_dec = 1'b0;
        case (state)
            S_FETCH: begin
                if (i_memReady) begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                case (i_opcode)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXEC;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_ADDI:      state_next = S_ADDIEX;
                    OP_J:         state_next = S_JUMP;
                    default: begin
                        state_next  = S_FETCH;
                        illegal_dec = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                // Only lw/sw reach MEMADR; anything else falls back to fetch.
                if (i_opcode == OP_LW) begin
                    state_next = S_MEMRD;
                end else if (i_opcode == OP_SW) begin
                    state_next = S_MEMWR;
                end else begin
                    state_next = S_FETCH;
                end
            end
            S_MEMRD: begin
                if (i_memReady) begin
                    state_next = S_MEMWB;
                end
            end
            S_MEMWB:  state_next = S_FETCH;
            S_MEMWR: begin
                if (i_memReady) begin
                    state_next = S_FETCH;
                end
            end
            S_EXEC:   state_next = S_ALUWB;
            S_ALUWB:  state_next = S_FETCH;
            S_BRANCH: state_next = S_FETCH;
            S_ADDIEX: state_next = S_ADDIWB;
            S_ADDIWB: state_next = S_FETCH;
            S_JUMP:   state_next = S_FETCH;
            default:  state_next = S_FETCH;
        endcase
    end

    always_comb begin
        o_aluOp       = 2'b00;
        o_aluSrcA     = 1'b0;
        o_aluSrcB     = 2'b00;
        o_pcSrc       = 2'b00;
        o_iorD        = 1'b0;
        o_regDst      = 1'b0;
        o_memtoReg    = 1'b0;
        pc_en_raw     = 1'b0;
        ir_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        reg_write_raw = 1'b0;
        case (state)
            S_FETCH: begin
                o_aluSrcB    = 2'b01;
                pc_en_raw    = i_memReady;
                ir_write_raw = i_memReady;
            end
            S_DECODE: begin
                o_aluSrcB = 2'b11;
            end
            S_MEMADR: begin
                o_aluSrcA = 1'b1;
                o_aluSrcB = 2'b10;
            end
            S_MEMRD: begin
                o_iorD = 1'b1;
            end
            S_MEMWB: begin
                o_memtoReg    = 1'b1;
                reg_write_raw = 1'b1;
            end
            S_MEMWR: begin
                o_iorD        = 1'b1;
                mem_write_raw = 1'b1;
            end
            S_EXEC: begin
                o_aluSrcA = 1'b1;
                o_aluOp   = 2'b10;
            end
            S_ALUWB: begin
                o_regDst      = 1'b1;
                reg_write_raw = 1'b1;
            end
            S_BRANCH: begin
                o_aluSrcA = 1'b1;
                o_aluOp   = 2'b01;
                o_pcSrc   = 2'b01;
                pc_en_raw = i_zero;
            end
            S_ADDIEX: begin
                o_aluSrcA = 1'b1;
                o_aluSrcB = 2'b10;
            end
            S_ADDIWB: begin
                reg_write_raw = 1'b1;
            end
            S_JUMP: begin
                o_pcSrc   = 2'b10;
                pc_en_raw = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // The state register already sits in FETCH during reset, but FETCH
    // passes i_memReady through to pcEn/irWrite, so every strobe is also
    // gated by i_rst_n to keep reset fully quiet with no clock edge needed.
    assign o_pcEn     = pc_en_raw     & i_rst_n;
    assign o_irWrite  = ir_write_raw  & i_rst_n;
    assign o_memWrite = mem_write_raw & i_rst_n;
    assign o_regWrite = reg_write_raw & i_rst_n;
    assign o_illegal  = illegal_dec   & i_rst_n;
    assign o_state    = state;

endmodule

// File: tb/tb_mc_control.sv
// Testbench for mc_control: table of directed instructions, randomized
// instruction stream against an instruction-level model, and hand-written
// reset sequences.

module tb_mc_control;

    localparam int ST_FETCH  = 0;
    localparam int ST_DECODE = 1;
    localparam int ST_MEMADR = 2;
    localparam int ST_MEMRD  = 3;
    localparam int ST_MEMWB  = 4;
    localparam int ST_MEMWR  = 5;
    localparam int ST_EXEC   = 6;
    localparam int ST_ALUWB  = 7;
    localparam int ST_BRANCH = 8;
    localparam int ST_ADDIEX = 9;
    localparam int ST_ADDIWB = 10;
    localparam int ST_JUMP   = 11;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    logic       i_clk;
    logic       i_rst_n;
    logic [5:0] i_opcode;
    logic       i_zero;
    logic       i_memReady;
    logic [1:0] o_aluOp;
    logic       o_aluSrcA;
    logic [1:0] o_aluSrcB;
    logic [1:0] o_pcSrc;
    logic       o_pcEn;
    logic       o_irWrite;
    logic       o_iorD;
    logic       o_memWrite;
    logic       o_regWrite;
    logic       o_regDst;
    logic       o_memtoReg;
    logic       o_illegal;
    logic [3:0] o_state;

    mc_control dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_opcode   (i_opcode),
        .i_zero     (i_zero),
        .i_memReady (i_memReady),
        .o_aluOp    (o_aluOp),
        .o_aluSrcA  (o_aluSrcA),
        .o_aluSrcB  (o_aluSrcB),
        .o_pcSrc    (o_pcSrc),
        .o_pcEn     (o_pcEn),
        .o_irWrite  (o_irWrite),
        .o_iorD     (o_iorD),
        .o_memWrite (o_memWrite),
        .o_regWrite (o_regWrite),
        .o_regDst   (o_regDst),
        .o_memtoReg (o_memtoReg),
        .o_illegal  (o_illegal),
        .o_state    (o_state)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One expected cycle of an instruction.
    typedef struct {
        int st;
        bit ready;
        bit zero;
        bit ill;
    } cyc_t;

    cyc_t exp_q[$];

    function automatic bit is_legal(input logic [5:0] op);
        return op == OP_R || op == OP_J || op == OP_BEQ ||
               op == OP_ADDI || op == OP_LW || op == OP_SW;
    endfunction

    function automatic cyc_t mk(input int st, input bit ready, input bit zero, input bit ill);
        cyc_t c;
        c.st = st; c.ready = ready; c.zero = zero; c.ill = ill;
        return c;
    endfunction

    // Instruction-level model: the cycle-by-cycle path an instruction takes,
    // with memory stalls placed where the memory is actually waited on.
    // Inputs that should be ignored get random values.
    task automatic build_expect(input logic [5:0] op, input bit z, input int fw, input int mw);
        bit ill;
        ill = !is_legal(op);
        exp_q.delete();
        for (int i = 0; i < fw; i++) exp_q.push_back(mk(ST_FETCH, 1'b0, 1'($urandom), 1'b0));
        exp_q.push_back(mk(ST_FETCH, 1'b1, 1'($urandom), 1'b0));
        exp_q.push_back(mk(ST_DECODE, 1'($urandom), 1'($urandom), ill));
        case (op)
            OP_LW: begin
                exp_q.push_back(mk(ST_MEMADR, 1'($urandom), 1'($urandom), 1'b0));
                for (int i = 0; i < mw; i++) exp_q.push_back(mk(ST_MEMRD, 1'b0, 1'($urandom), 1'b0));
                exp_q.push_back(mk(ST_MEMRD, 1'b1, 1'($urandom), 1'b0));
                exp_q.push_back(mk(ST_MEMWB, 1'($urandom), 1'($urandom), 1'b0));
            end
            OP_SW: begin
                exp_q.push_back(mk(ST_MEMADR, 1'($urandom), 1'($urandom), 1'b0));
                for (int i = 0; i < mw; i++) exp_q.push_back(mk(ST_MEMWR, 1'b0, 1'($urandom), 1'b0));
                exp_q.push_back(mk(ST_MEMWR, 1'b1, 1'($urandom), 1'b0));
            end
            OP_R: begin
                exp_q.push_back(mk(ST_EXEC, 1'($urandom), 1'($urandom), 1'b0));
                exp_q.push_back(mk(ST_ALUWB, 1'($urandom), 1'($urandom), 1'b0));
            end
            OP_BEQ:  exp_q.push_back(mk(ST_BRANCH, 1'($urandom), z, 1'b0));
            OP_ADDI: begin
                exp_q.push_back(mk(ST_ADDIEX, 1'($urandom), 1'($urandom), 1'b0));
                exp_q.push_back(mk(ST_ADDIWB, 1'($urandom), 1'($urandom), 1'b0));
            end
            OP_J:    exp_q.push_back(mk(ST_JUMP, 1'($urandom), 1'($urandom), 1'b0));
            default: begin
            end
        endcase
    endtask

    // {aluOp, aluSrcA, aluSrcB, pcSrc, iorD, regDst, memtoReg} per state.
    function automatic logic [10:0] exp_mux(input int st);
        case (st)
            ST_FETCH:  return {2'b00, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0};
            ST_DECODE: return {2'b00, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0};
            ST_MEMADR: return {2'b00, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0};
            ST_MEMRD:  return {2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0};
            ST_MEMWB:  return {2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1};
            ST_MEMWR:  return {2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0};
            ST_EXEC:   return {2'b10, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
            ST_ALUWB:  return {2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0};
            ST_BRANCH: return {2'b01, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0};
            ST_ADDIEX: return {2'b00, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0};
            ST_JUMP:   return {2'b00, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0};
            default:   return 11'd0;
        endcase
    endfunction

    task automatic check_cycle(input cyc_t e);
        logic [4:0] exp_str;
        logic [4:0] act_str;
        logic       pc;
        pc = (e.st == ST_FETCH && e.ready) || (e.st == ST_BRANCH && e.zero) || e.st == ST_JUMP;
        exp_str = {pc,
                   1'(e.st == ST_FETCH && e.ready),
                   1'(e.st == ST_MEMWR),
                   1'(e.st == ST_MEMWB || e.st == ST_ALUWB || e.st == ST_ADDIWB),
                   e.ill};
        act_str = {o_pcEn, o_irWrite, o_memWrite, o_regWrite, o_illegal};
        chk("state", int'(o_state), e.st);
        chk("strobes{pcEn,irWr,memWr,regWr,ill}", int'(act_str), int'(exp_str));
        chk("muxes", int'({o_aluOp, o_aluSrcA, o_aluSrcB, o_pcSrc, o_iorD, o_regDst, o_memtoReg}),
            int'(exp_mux(e.st)));
    endtask

    // Runs one instruction from FETCH until the DUT re-enters FETCH.
    // Entered and left #1 after a rising edge.
    task automatic run_instr(input logic [5:0] op, input bit z, input int fw, input int mw,
                             output int cyc, output int rw, output int mwc,
                             output int pc, output int ill);
        bit left;
        int k;
        build_expect(op, z, fw, mw);
        i_opcode = op;
        rw = 0; mwc = 0; pc = 0; ill = 0;
        left = 1'b0;
        k = 0;
        forever begin
            if (k >= 40) begin
                n_cmp++;
                n_bad++;
                $display("FAIL cycle_budget: op 0x%0h still in state %0d after %0d cycles", op, o_state, k);
                break;
            end
            if (k < exp_q.size()) begin
                i_memReady = exp_q[k].ready;
                i_zero     = exp_q[k].zero;
            end else begin
                i_memReady = 1'b1;
                i_zero     = 1'b0;
            end
            @(negedge i_clk);
            if (k < exp_q.size()) check_cycle(exp_q[k]);
            rw  += int'(o_regWrite);
            mwc += int'(o_memWrite);
            pc  += int'(o_pcEn);
            ill += int'(o_illegal);
            if (o_state != 4'd0) left = 1'b1;
            @(posedge i_clk);
            #1;
            k++;
            if (left && o_state == 4'd0) break;
        end
        cyc = k;
    endtask

    typedef struct {
        logic [5:0] op;
        bit         z;
        int         fw;
        int         mw;
        int         cyc;
        int         rw;
        int         mwc;
        int         pc;
        int         ill;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mv(input logic [5:0] op, input bit z, input int fw, input int mw,
                                input int cyc, input int rw, input int mwc, input int pc,
                                input int ill);
        vec_t v;
        v.op = op; v.z = z; v.fw = fw; v.mw = mw;
        v.cyc = cyc; v.rw = rw; v.mwc = mwc; v.pc = pc; v.ill = ill;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc, rw, mwc, pc, ill;
        logic [5:0] op;
        logic [5:0] legal [6];

        //            op       z  fw mw cyc rw mw pc ill
        vecs.push_back(mv(OP_LW,   0, 0, 0, 5, 1, 0, 1, 0));
        vecs.push_back(mv(OP_SW,   0, 0, 2, 6, 0, 3, 1, 0));
        vecs.push_back(mv(OP_BEQ,  1, 0, 0, 3, 0, 0, 2, 0));
        vecs.push_back(mv(OP_BEQ,  0, 0, 0, 3, 0, 0, 1, 0));
        vecs.push_back(mv(OP_R,    0, 0, 0, 4, 1, 0, 1, 0));
        vecs.push_back(mv(OP_J,    0, 0, 0, 3, 0, 0, 2, 0));
        vecs.push_back(mv(OP_ADDI, 0, 0, 0, 4, 1, 0, 1, 0));
        vecs.push_back(mv(6'h3F,   0, 0, 0, 2, 0, 0, 1, 1));
        vecs.push_back(mv(OP_LW,   0, 2, 1, 8, 1, 0, 1, 0));
        vecs.push_back(mv(OP_SW,   0, 1, 0, 5, 0, 1, 1, 0));

        i_rst_n    = 1'b0;
        i_memReady = 1'b1;
        i_zero     = 1'b0;
        i_opcode   = 6'h00;

        // Reset held with memory ready: all strobes quiet, state FETCH.
        @(negedge i_clk);
        chk("rst_state", int'(o_state), 0);
        chk("rst_strobes{pcEn,irWr,regWr,memWr,ill}",
            int'({o_pcEn, o_irWrite, o_regWrite, o_memWrite, o_illegal}), 0);
        chk("rst_muxes", int'({o_aluOp, o_aluSrcA, o_aluSrcB, o_pcSrc, o_iorD}), int'(8'b00_0_01_00_0));
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        #1;
        chk("release_pcEn_irWrite", int'({o_pcEn, o_irWrite}), 3);

        foreach (vecs[i]) begin
            run_instr(vecs[i].op, vecs[i].z, vecs[i].fw, vecs[i].mw, cyc, rw, mwc, pc, ill);
            chk($sformatf("vec%0d_cycles", i), cyc, vecs[i].cyc);
            chk($sformatf("vec%0d_regWrite_cycles", i), rw, vecs[i].rw);
            chk($sformatf("vec%0d_memWrite_cycles", i), mwc, vecs[i].mwc);
            chk($sformatf("vec%0d_pcEn_cycles", i), pc, vecs[i].pc);
            chk($sformatf("vec%0d_illegal_cycles", i), ill, vecs[i].ill);
        end

        legal = '{OP_R, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW};
        for (int n = 0; n < 80; n++) begin
            int sel;
            int fw;
            int mw;
            bit z;
            int exp_cyc;
            sel = int'($urandom_range(0, 7));
            if (sel < 6) begin
                op = legal[sel];
            end else begin
                do op = 6'($urandom_range(0, 63)); while (is_legal(op));
            end
            fw = int'($urandom_range(0, 2));
            mw = int'($urandom_range(0, 2));
            z  = 1'($urandom);
            run_instr(op, z, fw, mw, cyc, rw, mwc, pc, ill);
            // Zero-wait latency plus one cycle per stall in a waiting state.
            case (op)
                OP_LW:   exp_cyc = 5 + fw + mw;
                OP_SW:   exp_cyc = 4 + fw + mw;
                OP_R:    exp_cyc = 4 + fw;
                OP_ADDI: exp_cyc = 4 + fw;
                OP_BEQ:  exp_cyc = 3 + fw;
                OP_J:    exp_cyc = 3 + fw;
                default: exp_cyc = 2 + fw;
            endcase
            chk($sformatf("rand%0d_op%0h_cycles", n, op), cyc, exp_cyc);
            chk($sformatf("rand%0d_op%0h_illegal", n, op), ill, int'(!is_legal(op)));
        end

        // Reset dropped in the middle of a stalled store.
        i_opcode   = OP_SW;
        i_memReady = 1'b1;
        repeat (3) begin
            @(posedge i_clk);
            #1;
        end
        i_memReady = 1'b0;
        @(negedge i_clk);
        chk("memwr_state", int'(o_state), ST_MEMWR);
        chk("memwr_strobe", int'(o_memWrite), 1);
        #2;
        i_rst_n    = 1'b0;
        i_memReady = 1'b1;
        #1;
        chk("abort_memWrite", int'(o_memWrite), 0);
        chk("abort_state", int'(o_state), 0);
        chk("abort_pcEn_irWrite", int'({o_pcEn, o_irWrite, o_regWrite}), 0);
        @(posedge i_clk);
        #1;
        chk("abort_hold_state", int'(o_state), 0);
        i_rst_n = 1'b1;
        #1;
        chk("abort_release_fetch", int'({o_pcEn, o_irWrite}), 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
